// File: rtl/mempool_dma_splitter.sv
// Splits one linear L2<->L1 DMA request into L1-granule-aligned chunks, steers each chunk
// to the backend owning that granule, and reports completion once all chunks are done.
module mempool_dma_splitter #(
    parameter int unsigned NumBackends    = 4,
    parameter int unsigned ChunkBytes     = 256,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned LenWidth       = 32,
    parameter int unsigned MaxOutstanding = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_l2_addr_i,
    input  logic [AddrWidth-1:0]   req_l1_addr_i,
    input  logic [LenWidth-1:0]    req_num_bytes_i,
    input  logic                   req_dir_i,
    output logic [NumBackends-1:0] chk_valid_o,
    input  logic [NumBackends-1:0] chk_ready_i,
    output logic [AddrWidth-1:0]   chk_l2_addr_o,
    output logic [AddrWidth-1:0]   chk_l1_addr_o,
    output logic [LenWidth-1:0]    chk_num_bytes_o,
    output logic                   chk_dir_o,
    input  logic [NumBackends-1:0] bk_done_i,
    output logic                   busy_o,
    output logic                   trans_complete_o
);
    localparam int unsigned OffW = $clog2(ChunkBytes);
    localparam int unsigned SelW = (NumBackends > 1) ? $clog2(NumBackends) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic [1:0] {IDLE, SPLIT, DRAIN} state_e;

    state_e              state_q;
    logic [LenWidth-1:0] rem_q;   // bytes not yet issued, including the chunk on display
    logic [CntW-1:0]     out_q;

    // Outstanding accounting: one issue and any number of dones fold into one update.
    logic                issue;
    int unsigned         pop;
    int unsigned         out_sum;
    logic [CntW-1:0]     out_nxt;
    logic                can_issue;

    always_comb begin
        issue = |(chk_valid_o & chk_ready_i);
        pop   = 0;
        for (int i = 0; i < int'(NumBackends); i++) begin
            pop = pop + {31'b0, bk_done_i[i]};
        end
        out_sum   = {{(32 - CntW){1'b0}}, out_q} + {31'b0, issue};
        out_nxt   = (out_sum >= pop) ? CntW'(out_sum - pop) : '0;
        can_issue = {{(32 - CntW){1'b0}}, out_nxt} < MaxOutstanding;
    end

    // The chunk registers double as the address pointers; the next chunk is either the
    // request itself, the current chunk advanced by its length, or the current one held.
    logic [AddrWidth-1:0]   nxt_l1;
    logic [AddrWidth-1:0]   nxt_l2;
    logic [LenWidth-1:0]    nxt_rem;
    logic [LenWidth-1:0]    nxt_room;
    logic [LenWidth-1:0]    nxt_len;
    logic [SelW-1:0]        nxt_sel;
    logic [NumBackends-1:0] nxt_onehot;

    always_comb begin
        nxt_l1  = chk_l1_addr_o;
        nxt_l2  = chk_l2_addr_o;
        nxt_rem = rem_q;
        if (state_q == IDLE) begin
            nxt_l1  = req_l1_addr_i;
            nxt_l2  = req_l2_addr_i;
            nxt_rem = req_num_bytes_i;
        end else if (issue) begin
            nxt_l1  = chk_l1_addr_o + AddrWidth'(chk_num_bytes_o);
            nxt_l2  = chk_l2_addr_o + AddrWidth'(chk_num_bytes_o);
            nxt_rem = rem_q - chk_num_bytes_o;
        end
        nxt_room   = LenWidth'(ChunkBytes) - LenWidth'(nxt_l1[OffW-1:0]);
        nxt_len    = (nxt_rem < nxt_room) ? nxt_rem : nxt_room;
        nxt_sel    = (NumBackends > 1) ? nxt_l1[OffW +: SelW] : '0;
        nxt_onehot = '0;
        nxt_onehot[nxt_sel] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            rem_q            <= '0;
            out_q            <= '0;
            req_ready_o      <= 1'b0;
            chk_valid_o      <= '0;
            chk_l2_addr_o    <= '0;
            chk_l1_addr_o    <= '0;
            chk_num_bytes_o  <= '0;
            chk_dir_o        <= 1'b0;
            busy_o           <= 1'b0;
            trans_complete_o <= 1'b0;
        end else begin
            out_q            <= out_nxt;
            trans_complete_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o     <= 1'b0;
                        busy_o          <= 1'b1;
                        chk_dir_o       <= req_dir_i;
                        chk_l1_addr_o   <= nxt_l1;
                        chk_l2_addr_o   <= nxt_l2;
                        chk_num_bytes_o <= nxt_len;
                        rem_q           <= nxt_rem;
                        if (nxt_rem == '0) begin
                            state_q <= DRAIN;
                        end else begin
                            state_q     <= SPLIT;
                            chk_valid_o <= can_issue ? nxt_onehot : '0;
                        end
                    end
                end
                SPLIT: begin
                    chk_l1_addr_o   <= nxt_l1;
                    chk_l2_addr_o   <= nxt_l2;
                    chk_num_bytes_o <= nxt_len;
                    rem_q           <= nxt_rem;
                    if (issue && nxt_rem == '0) begin
                        state_q     <= DRAIN;
                        chk_valid_o <= '0;
                    end else begin
                        // A held chunk keeps its slot; a stalled one waits for a free slot.
                        chk_valid_o <= can_issue ? nxt_onehot : '0;
                    end
                end
                DRAIN: begin
                    if (out_nxt == '0) begin
                        state_q          <= IDLE;
                        trans_complete_o <= 1'b1;
                        busy_o           <= 1'b0;
                        req_ready_o      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A backend may only report chunks it was actually given.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({{(32 - CntW){1'b0}}, out_q} >= pop));
    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(chk_valid_o));

endmodule
